meta_alu_sched: RTL and testbench
=================================

# meta_alu_sched

Pairs each packet's compound metadata (PHV metadata plus comparison instruction) with its match-table action and issues the pair to the stage's metadata-modification ALU in a single cycle. The ALU only updates metadata when action and metadata arrive together, and lookup latency varies, so this block buffers both streams and issues strictly in order. It sits in each RMT stage between the parser/previous-stage metadata path, the lookup engine, and the ALU, and tracks results still in flight.

## Interface
- STAGE, 0, stage index; informational only.
- META_LEN, 256, metadata width.
- COMP_LEN, 100, comparison-instruction width; entry width W = META_LEN+COMP_LEN.
- ACTION_LEN, 25, action word width.
- DEPTH, 4, depth of each FIFO; power of two, at least 2.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both FIFOs and the error flags.
- meta_in  in  W  compound metadata from upstream.
- meta_valid_in  in  1  meta_in valid.
- meta_ready_out  out  1  metadata FIFO can accept.
- action_in  in  ACTION_LEN  action from lookup engine.
- action_valid_in  in  1  action_in valid.
- alu_meta_out  out  W  metadata issued to ALU.
- alu_meta_valid_out  out  1  issue strobe (metadata).
- alu_action_out  out  ACTION_LEN  action issued to ALU.
- alu_action_valid_out  out  1  issue strobe (action); always equal to alu_meta_valid_out.
- alu_done_in  in  1  ALU output-valid pulse, one per completed pair.
- inflight_out  out  clog2(DEPTH)+2  issued pairs not yet completed.
- idle_out  out  1  both FIFOs empty and inflight_out == 0.
- err_out  out  3  sticky flags: [0] action overflow, [1] metadata overflow, [2] done underflow.

## Operation
- Two FIFOs of DEPTH entries: M (metadata) and A (action). Each has a count register of width clog2(DEPTH)+1.
- M push: meta_valid_in && meta_ready_out, where meta_ready_out = (M count < DEPTH). The ready signal is combinational from the count only. A pop in the same cycle does not make a full FIFO ready.
- If meta_valid_in is high while M is full, the word is dropped and err_out[1] is set.
- A has no backpressure, because the lookup engine cannot stall. If action_valid_in is high while A is full, the action is dropped, err_out[0] is set, and A and M stay unchanged.
- Issue condition: M non-empty and A non-empty. Both heads pop in the same cycle, and the outputs register the two heads together. One issue per cycle at most, in strict FIFO order. Opcode is not inspected; unsupported opcodes pass through.
- No issue cycle: both valid outputs go to 0. alu_meta_out and alu_action_out hold their last values.
- Inflight counter:
  - +1 on issue, −1 on alu_done_in, unchanged when both occur in the same cycle.
  - alu_done_in while the counter is 0 (with no issue that cycle) leaves it at 0 and sets err_out[2].
  - Saturates at its maximum value.
- Pointers wrap modulo DEPTH. Counts never exceed DEPTH.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and both operations take effect.
- flush:
  - Zeroes both counts and pointers, suppresses issue and push that cycle, and clears err_out.
  - Does not clear inflight_out, because results already in the ALU still return.
- Reset values:
  - All outputs are 0, except meta_ready_out = 1 and idle_out = 1 (both follow from count 0).
  - FIFOs empty, inflight 0, err_out 0.
  - A reset mid-operation discards every buffered and in-flight entry. A later alu_done_in with inflight 0 sets err_out[2].

## Timing
- Push at edge N. Issue is evaluated from registered counts, so the pair appears on the outputs at edge N+1 at the earliest, when the other FIFO already holds an entry. Minimum latency is 1 cycle.
- A waiting for M, or M waiting for A: the pair issues on the edge after the later of the two pushes.
- Throughput: one pair per cycle when both streams are continuous.
- meta_ready_out drops in the cycle after the edge that makes M count reach DEPTH.
- err_out bits assert on the edge following the offending cycle.
- inflight_out and idle_out reflect the state as of the previous edge.

## Test plan
- Meta M0 at cycle 0, action A0 (opcode 1100) at cycle 3 → alu_meta_out = M0 and alu_action_out = A0 with both valids high in exactly cycle 4; inflight_out = 1; after alu_done_in, inflight_out = 0 and idle_out = 1.
- Actions A0..A2 arrive first, then meta M0..M2 on consecutive cycles → three back-to-back issues pairing M0/A0, M1/A1, M2/A2.
- Push 5 metadata words with no actions (DEPTH = 4) → meta_ready_out = 0 after the 4th word; the 5th word is dropped; err_out[1] = 1; 4 pairs issue later.
- Five actions with no metadata → 5th action dropped, err_out[0] = 1, only A0..A3 are later paired.
- Issue and alu_done_in in the same cycle with inflight = 1 → inflight stays 1. alu_done_in with inflight = 0 → err_out[2] = 1, inflight stays 0.
- Assert flush with 2 metadata words buffered and 1 pair in flight → FIFOs empty, err_out = 0, inflight_out = 1. Then assert rst_n low mid-issue → all valid outputs 0 and meta_ready_out = 1 immediately.

Source files
------------

// File: rtl/meta_alu_sched.sv
// Pairs PHV metadata with its match action and issues both to the stage ALU in order.
// Tracks issued pairs until the ALU reports completion.
module meta_alu_sched #(
    parameter int STAGE      = 0,
    parameter int META_LEN   = 256,
    parameter int COMP_LEN   = 100,
    parameter int ACTION_LEN = 25,
    parameter int DEPTH      = 4,
    localparam int W         = META_LEN + COMP_LEN,
    localparam int CW        = $clog2(DEPTH) + 1,
    localparam int IW        = $clog2(DEPTH) + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [W-1:0]          meta_in,
    input  logic                  meta_valid_in,
    output logic                  meta_ready_out,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid_in,
    output logic [W-1:0]          alu_meta_out,
    output logic                  alu_meta_valid_out,
    output logic [ACTION_LEN-1:0] alu_action_out,
    output logic                  alu_action_valid_out,
    input  logic                  alu_done_in,
    output logic [IW-1:0]         inflight_out,
    output logic                  idle_out,
    output logic [2:0]            err_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [IW-1:0] IMAX = '1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0) begin : g_bad_cfg
        $error("meta_alu_sched: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]          m_mem [DEPTH];
    logic [ACTION_LEN-1:0] a_mem [DEPTH];
    logic [PW-1:0]         m_wp, m_rp, a_wp, a_rp;
    logic [CW-1:0]         m_cnt, a_cnt;
    logic [IW-1:0]         inflight;
    logic [2:0]            err;
    logic                  issue_q;
    logic                  m_push, a_push, issue;
    logic                  m_ovf, a_ovf, d_unf;

    // Ready looks only at the registered count; a same-cycle pop never opens a full FIFO.
    assign meta_ready_out = (m_cnt < FULL);
    assign m_push = meta_valid_in && meta_ready_out && !flush;
    assign m_ovf  = meta_valid_in && !meta_ready_out;
    assign a_push = action_valid_in && (a_cnt != FULL) && !flush;
    assign a_ovf  = action_valid_in && (a_cnt == FULL);
    assign issue  = (m_cnt != '0) && (a_cnt != '0) && !flush;
    assign d_unf  = alu_done_in && !issue && (inflight == '0);

    always_ff @(posedge clk) begin
        if (m_push) m_mem[m_wp] <= meta_in;
        if (a_push) a_mem[a_wp] <= action_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wp  <= '0;
            m_rp  <= '0;
            a_wp  <= '0;
            a_rp  <= '0;
            m_cnt <= '0;
            a_cnt <= '0;
        end else if (flush) begin
            m_wp  <= '0;
            m_rp  <= '0;
            a_wp  <= '0;
            a_rp  <= '0;
            m_cnt <= '0;
            a_cnt <= '0;
        end else begin
            if (m_push) m_wp <= m_wp + 1'b1;
            if (a_push) a_wp <= a_wp + 1'b1;
            if (issue) begin
                m_rp <= m_rp + 1'b1;
                a_rp <= a_rp + 1'b1;
            end
            m_cnt <= m_cnt + CW'(m_push) - CW'(issue);
            a_cnt <= a_cnt + CW'(a_push) - CW'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q        <= 1'b0;
            alu_meta_out   <= '0;
            alu_action_out <= '0;
        end else begin
            issue_q <= issue;
            if (issue) begin
                alu_meta_out   <= m_mem[m_rp];
                alu_action_out <= a_mem[a_rp];
            end
        end
    end

    // Flush leaves the in-flight count alone: those results still come back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({issue, alu_done_in})
                2'b10: if (inflight != IMAX) inflight <= inflight + 1'b1;
                2'b01: if (inflight != '0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (flush) begin
            err <= '0;
        end else begin
            err <= err | {d_unf, m_ovf, a_ovf};
        end
    end

    assign alu_meta_valid_out   = issue_q;
    assign alu_action_valid_out = issue_q;
    assign inflight_out         = inflight;
    assign err_out              = err;
    assign idle_out = (m_cnt == '0) && (a_cnt == '0) && (inflight == '0);

endmodule

// File: tb/tb_meta_alu_sched.sv
// Directed bench for meta_alu_sched: pairing order, overflow drops, inflight
// accounting, flush and asynchronous reset.
module tb_meta_alu_sched;

    localparam int W  = 356;
    localparam int AL = 25;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [W-1:0]  meta_in;
    logic          meta_valid_in;
    logic          meta_ready_out;
    logic [AL-1:0] action_in;
    logic          action_valid_in;
    logic [W-1:0]  alu_meta_out;
    logic          alu_meta_valid_out;
    logic [AL-1:0] alu_action_out;
    logic          alu_action_valid_out;
    logic          alu_done_in;
    logic [IW-1:0] inflight_out;
    logic          idle_out;
    logic [2:0]    err_out;

    int total = 0;
    int bad   = 0;

    meta_alu_sched dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush                (flush),
        .meta_in              (meta_in),
        .meta_valid_in        (meta_valid_in),
        .meta_ready_out       (meta_ready_out),
        .action_in            (action_in),
        .action_valid_in      (action_valid_in),
        .alu_meta_out         (alu_meta_out),
        .alu_meta_valid_out   (alu_meta_valid_out),
        .alu_action_out       (alu_action_out),
        .alu_action_valid_out (alu_action_valid_out),
        .alu_done_in          (alu_done_in),
        .inflight_out         (inflight_out),
        .idle_out             (idle_out),
        .err_out              (err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mv(input int i);
        logic [W-1:0] v;
        v = W'(32'h1111_0001 * (i + 1));
        v = v | (W'(i + 7) << 300);
        return v;
    endfunction

    function automatic logic [AL-1:0] av(input int i);
        return {4'hC, 21'(i + 5)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string tag, input int mi, input int ai);
        chk({tag, "_mv"}, alu_meta_valid_out, 1'b1);
        chk({tag, "_av"}, alu_action_valid_out, 1'b1);
        chk({tag, "_m"}, alu_meta_out, mv(mi));
        chk({tag, "_a"}, alu_action_out, av(ai));
    endtask

    task automatic chk_noissue(input string tag);
        chk({tag, "_mv0"}, alu_meta_valid_out, 1'b0);
        chk({tag, "_av0"}, alu_action_valid_out, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        meta_in = '0;
        meta_valid_in = 1'b0;
        action_in = '0;
        action_valid_in = 1'b0;
        alu_done_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_noissue("rst");
        chk("rst_rdy", meta_ready_out, 1'b1);
        chk("rst_idle", idle_out, 1'b1);
        chk("rst_infl", inflight_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_mo", alu_meta_out, 0);
        chk("rst_ao", alu_action_out, 0);
        rst_n = 1'b1;
        tick();

        // Meta first, action three cycles later
        meta_in = mv(0);
        meta_valid_in = 1'b1;
        tick();
        meta_valid_in = 1'b0;
        chk_noissue("t1_c0");
        tick();
        tick();
        action_in = av(0);
        action_valid_in = 1'b1;
        tick();
        action_valid_in = 1'b0;
        chk_noissue("t1_c3");
        tick();
        chk_pair("t1_c4", 0, 0);
        chk("t1_infl", inflight_out, 1);
        chk("t1_busy", idle_out, 1'b0);
        alu_done_in = 1'b1;
        tick();
        alu_done_in = 1'b0;
        chk_noissue("t1_c5");
        chk("t1_hold_m", alu_meta_out, mv(0));
        chk("t1_infl0", inflight_out, 0);
        chk("t1_idle", idle_out, 1'b1);

        // Actions first, then back-to-back metadata
        for (int i = 0; i < 3; i++) begin
            action_in = av(10 + i);
            action_valid_in = 1'b1;
            tick();
        end
        action_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            meta_in = mv(10 + i);
            meta_valid_in = 1'b1;
            tick();
            if (i == 0) chk_noissue("t2_first");
            else chk_pair($sformatf("t2_p%0d", i - 1), 10 + i - 1, 10 + i - 1);
        end
        meta_valid_in = 1'b0;
        tick();
        chk_pair("t2_p2", 12, 12);
        tick();
        chk_noissue("t2_end");
        chk("t2_infl", inflight_out, 3);
        alu_done_in = 1'b1;
        repeat (3) tick();
        alu_done_in = 1'b0;
        chk("t2_infl0", inflight_out, 0);

        // Metadata overflow
        for (int i = 0; i < 5; i++) begin
            meta_in = mv(20 + i);
            meta_valid_in = 1'b1;
            tick();
            if (i == 2) chk("t3_rdy3", meta_ready_out, 1'b1);
            if (i == 3) begin
                chk("t3_rdy4", meta_ready_out, 1'b0);
                chk("t3_err_pre", err_out, 3'b000);
            end
        end
        meta_valid_in = 1'b0;
        chk("t3_err", err_out, 3'b010);
        for (int i = 0; i < 4; i++) begin
            action_in = av(30 + i);
            action_valid_in = 1'b1;
            tick();
            if (i > 0) chk_pair($sformatf("t3_p%0d", i - 1), 20 + i - 1, 30 + i - 1);
        end
        action_valid_in = 1'b0;
        tick();
        chk_pair("t3_p3", 23, 33);
        tick();
        chk_noissue("t3_dropped");
        chk("t3_rdy", meta_ready_out, 1'b1);
        chk("t3_infl", inflight_out, 4);
        alu_done_in = 1'b1;
        repeat (4) tick();
        alu_done_in = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_err", err_out, 0);

        // Action overflow
        for (int i = 0; i < 5; i++) begin
            action_in = av(40 + i);
            action_valid_in = 1'b1;
            tick();
        end
        action_valid_in = 1'b0;
        chk("t4_err", err_out, 3'b001);
        for (int i = 0; i < 4; i++) begin
            meta_in = mv(50 + i);
            meta_valid_in = 1'b1;
            tick();
            if (i > 0) chk_pair($sformatf("t4_p%0d", i - 1), 50 + i - 1, 40 + i - 1);
        end
        meta_valid_in = 1'b0;
        tick();
        chk_pair("t4_p3", 53, 43);
        tick();
        chk_noissue("t4_end");
        chk("t4_infl", inflight_out, 4);
        alu_done_in = 1'b1;
        repeat (4) tick();
        alu_done_in = 1'b0;
        chk("t4_idle", idle_out, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Issue and done together, then done underflow
        meta_in = mv(60);
        action_in = av(60);
        meta_valid_in = 1'b1;
        action_valid_in = 1'b1;
        tick();
        meta_in = mv(61);
        action_in = av(61);
        tick();
        chk_pair("t5_p0", 60, 60);
        chk("t5_infl1", inflight_out, 1);
        meta_valid_in = 1'b0;
        action_valid_in = 1'b0;
        alu_done_in = 1'b1;
        tick();
        chk_pair("t5_p1", 61, 61);
        chk("t5_infl_same", inflight_out, 1);
        tick();
        chk("t5_infl0", inflight_out, 0);
        chk("t5_err_pre", err_out, 3'b000);
        tick();
        alu_done_in = 1'b0;
        chk("t5_err", err_out, 3'b100);
        chk("t5_infl_stay", inflight_out, 0);

        // Flush with two metadata words buffered and one pair in flight
        meta_in = mv(70);
        action_in = av(70);
        meta_valid_in = 1'b1;
        action_valid_in = 1'b1;
        tick();
        action_valid_in = 1'b0;
        meta_in = mv(71);
        tick();
        chk_pair("t6_p0", 70, 70);
        meta_in = mv(72);
        tick();
        meta_valid_in = 1'b0;
        chk("t6_infl", inflight_out, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_err", err_out, 0);
        chk("t6_infl_kept", inflight_out, 1);
        chk("t6_rdy", meta_ready_out, 1'b1);
        chk_noissue("t6_fl");
        action_in = av(80);
        action_valid_in = 1'b1;
        tick();
        action_valid_in = 1'b0;
        tick();
        chk_noissue("t6_empty");

        // Reset while a pair is on the outputs
        meta_in = mv(80);
        meta_valid_in = 1'b1;
        tick();
        meta_valid_in = 1'b0;
        tick();
        chk_pair("t7_p", 80, 80);
        chk("t7_infl", inflight_out, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_noissue("t7_rst");
        chk("t7_rdy", meta_ready_out, 1'b1);
        chk("t7_infl0", inflight_out, 0);
        chk("t7_idle", idle_out, 1'b1);
        chk("t7_err0", err_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        alu_done_in = 1'b1;
        tick();
        alu_done_in = 1'b0;
        chk("t7_err", err_out, 3'b100);
        chk("t7_infl_stay", inflight_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
